// File: rtl/fp8_mac_pe_v2.sv
// FP8 (E4M3/E5M2) multiply-accumulate processing element for an output-stationary systolic
// array: 2-stage product pipeline, saturating fixed-point accumulator, drain shift chain.
module fp8_mac_pe_v2 #(
    parameter int ACC_W     = 24,
    parameter int FRAC_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             fmt_sel,
    input  logic             in_valid,
    input  logic [7:0]       a_in,
    input  logic [7:0]       b_in,
    output logic [7:0]       a_out,
    output logic [7:0]       b_out,
    output logic             out_valid,
    input  logic             drain_en,
    input  logic [ACC_W-1:0] drain_in,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic             nan_flag
);
    localparam int WIDE_W = ACC_W + 8;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic fp8_special(input logic [7:0] v, input logic fmt);
        logic sp;
        if (fmt == 1'b0) sp = (v[6:3] == 4'hF) && (v[2:0] == 3'h7);
        else             sp = (v[6:2] == 5'h1F);
        return sp;
    endfunction

    // Significand with hidden bit; denormals (exp field 0) get a hidden 0.
    function automatic logic [3:0] fp8_sig(input logic [7:0] v, input logic fmt);
        logic [3:0] s;
        if (fmt == 1'b0) s = {(v[6:3] != 4'h0), v[2:0]};
        else             s = {1'b0, (v[6:2] != 5'h00), v[1:0]};
        return s;
    endfunction

    function automatic logic signed [5:0] fp8_exp(input logic [7:0] v, input logic fmt);
        logic signed [5:0] e;
        if (fmt == 1'b0) begin
            if (v[6:3] == 4'h0) e = -6'sd6;
            else                e = $signed({2'b00, v[6:3]}) - 6'sd7;
        end else begin
            if (v[6:2] == 5'h00) e = -6'sd14;
            else                 e = $signed({1'b0, v[6:2]}) - 6'sd15;
        end
        return e;
    endfunction

    logic [7:0]        a_r, b_r;
    logic              valid_r;
    logic [3:0]        sig_a_s, sig_b_s;
    logic signed [5:0] exp_a_s, exp_b_s;
    logic              special_s, nan_seen_s;
    logic [7:0]        mprod_s;
    logic signed [6:0] exp_sum_s;

    logic              p1_valid_r, p1_sign_r, p1_fmt_r;
    logic [7:0]        p1_mprod_r;
    logic signed [6:0] p1_exp_r;

    int                shift_s;
    logic [WIDE_W-1:0] wide_s;
    logic              big_s, mag_ovf_s, acc_sat_s;
    logic [ACC_W-1:0]  mag_s, acc_next_s;
    logic [ACC_W:0]    sum_s;
    logic [ACC_W-1:0]  acc_r;
    logic              ovf_r, nan_r;

    // Stage-1 operand decode and significand multiply.
    always_comb begin
        sig_a_s    = fp8_sig(a_in, fmt_sel);
        sig_b_s    = fp8_sig(b_in, fmt_sel);
        exp_a_s    = fp8_exp(a_in, fmt_sel);
        exp_b_s    = fp8_exp(b_in, fmt_sel);
        special_s  = fp8_special(a_in, fmt_sel) | fp8_special(b_in, fmt_sel);
        nan_seen_s = in_valid & special_s;
        mprod_s    = {4'h0, sig_a_s} * {4'h0, sig_b_s};
        exp_sum_s  = {exp_a_s[5], exp_a_s} + {exp_b_s[5], exp_b_s};
    end

    // Neighbour forwarding, independent of clear and drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= 8'h00;
            b_r     <= 8'h00;
            valid_r <= 1'b0;
        end else begin
            a_r     <= a_in;
            b_r     <= b_in;
            valid_r <= in_valid;
        end
    end

    // Stage-1 pipeline register; format is captured so later fmt_sel changes cannot alter it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid_r <= 1'b0;
            p1_sign_r  <= 1'b0;
            p1_fmt_r   <= 1'b0;
            p1_mprod_r <= 8'h00;
            p1_exp_r   <= 7'sd0;
        end else begin
            p1_valid_r <= in_valid & ~special_s;
            p1_sign_r  <= a_in[7] ^ b_in[7];
            p1_fmt_r   <= fmt_sel;
            p1_mprod_r <= mprod_s;
            p1_exp_r   <= exp_sum_s;
        end
    end

    // Stage-2 alignment to the accumulator fixed point, then saturating add/subtract.
    always_comb begin
        shift_s = int'(p1_exp_r) + FRAC_BITS - (p1_fmt_r ? 32'sd4 : 32'sd6);
        wide_s  = '0;
        big_s   = 1'b0;
        if (shift_s >= ACC_W) begin
            big_s = (p1_mprod_r != 8'h00);
        end else if (shift_s >= 32'sd0) begin
            wide_s = {{ACC_W{1'b0}}, p1_mprod_r} << shift_s;
        end else if (shift_s > -32'sd8) begin
            wide_s = {{ACC_W{1'b0}}, p1_mprod_r} >> (-shift_s);
        end else begin
            wide_s = '0;
        end
        mag_ovf_s = big_s || (wide_s > {8'h00, ACC_MAX});
        if (mag_ovf_s) mag_s = ACC_MAX;
        else           mag_s = wide_s[ACC_W-1:0];
        if (p1_sign_r) sum_s = {acc_r[ACC_W-1], acc_r} - {1'b0, mag_s};
        else           sum_s = {acc_r[ACC_W-1], acc_r} + {1'b0, mag_s};
        acc_sat_s = (sum_s[ACC_W] != sum_s[ACC_W-1]);
        if (!acc_sat_s)        acc_next_s = sum_s[ACC_W-1:0];
        else if (sum_s[ACC_W]) acc_next_s = ACC_MIN;
        else                   acc_next_s = ACC_MAX;
    end

    // Accumulator and sticky flags: clear beats drain beats accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
            ovf_r <= 1'b0;
            nan_r <= 1'b0;
        end else if (clear) begin
            acc_r <= '0;
            ovf_r <= 1'b0;
            nan_r <= 1'b0;
        end else begin
            if (drain_en) begin
                acc_r <= drain_in;
            end else if (p1_valid_r) begin
                acc_r <= acc_next_s;
                if (mag_ovf_s || acc_sat_s) ovf_r <= 1'b1;
            end else begin
                acc_r <= acc_r;
            end
            if (nan_seen_s) nan_r <= 1'b1;
        end
    end

    assign a_out     = a_r;
    assign b_out     = b_r;
    assign out_valid = valid_r;
    assign acc_out   = acc_r;
    assign ovf       = ovf_r;
    assign nan_flag  = nan_r;

endmodule

// File: tb/tb_fp8_mac_pe_v2.sv
// Directed bench for fp8_mac_pe_v2: three PEs in a drain chain sharing operands; PE u2 is the
// chain tail and the main observation point.
module tb_fp8_mac_pe_v2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        fmt_sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  a_in = 8'h00;
    logic [7:0]  b_in = 8'h00;
    logic        drain_en = 1'b0;
    logic [23:0] head_in = 24'h000000;

    logic [23:0] acc0, acc1, acc_tail;
    logic [7:0]  a0, b0, a1, b1, a2, b2;
    logic        v0, v1, v2, ovf0, ovf1, ovf2, nan0, nan1, nan2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp8_mac_pe_v2 #(.ACC_W(24), .FRAC_BITS(8)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .fmt_sel(fmt_sel), .in_valid(in_valid),
        .a_in(a_in), .b_in(b_in), .a_out(a0), .b_out(b0), .out_valid(v0),
        .drain_en(drain_en), .drain_in(head_in), .acc_out(acc0), .ovf(ovf0), .nan_flag(nan0));
    fp8_mac_pe_v2 #(.ACC_W(24), .FRAC_BITS(8)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .fmt_sel(fmt_sel), .in_valid(in_valid),
        .a_in(a_in), .b_in(b_in), .a_out(a1), .b_out(b1), .out_valid(v1),
        .drain_en(drain_en), .drain_in(acc0), .acc_out(acc1), .ovf(ovf1), .nan_flag(nan1));
    fp8_mac_pe_v2 #(.ACC_W(24), .FRAC_BITS(8)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .fmt_sel(fmt_sel), .in_valid(in_valid),
        .a_in(a_in), .b_in(b_in), .a_out(a2), .b_out(b2), .out_valid(v2),
        .drain_en(drain_en), .drain_in(acc1), .acc_out(acc_tail), .ovf(ovf2), .nan_flag(nan2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a_in     = 8'h00;
        b_in     = 8'h00;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        n_checks++; if (acc_tail !== 24'h000000) begin n_fail++; $display("FAIL reset_acc: got %h want %h", acc_tail, 24'h000000); end
        n_checks++; if (a2 !== 8'h00) begin n_fail++; $display("FAIL reset_a_out: got %h want %h", a2, 8'h00); end
        n_checks++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want %b", v2, 1'b0); end
        n_checks++; if (ovf2 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want %b", ovf2, 1'b0); end
        n_checks++; if (nan2 !== 1'b0) begin n_fail++; $display("FAIL reset_nan: got %b want %b", nan2, 1'b0); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unit();
        fmt_sel = 1'b0;
        drive(8'h38, 8'h38);
        tick();
        n_checks++; if (v2 !== 1'b1) begin n_fail++; $display("FAIL fwd_valid: got %b want %b", v2, 1'b1); end
        n_checks++; if (a2 !== 8'h38) begin n_fail++; $display("FAIL fwd_a: got %h want %h", a2, 8'h38); end
        n_checks++; if (b2 !== 8'h38) begin n_fail++; $display("FAIL fwd_b: got %h want %h", b2, 8'h38); end
        n_checks++; if (acc_tail !== 24'h000000) begin n_fail++; $display("FAIL unit_latency1: got %h want %h", acc_tail, 24'h000000); end
        idle();
        tick();
        n_checks++; if (acc_tail !== 24'h000100) begin n_fail++; $display("FAIL unit_acc: got %h want %h", acc_tail, 24'h000100); end
        n_checks++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL fwd_valid_drop: got %b want %b", v2, 1'b0); end
        tick();
        n_checks++; if (acc_tail !== 24'h000100) begin n_fail++; $display("FAIL unit_hold: got %h want %h", acc_tail, 24'h000100); end
    endtask

    task automatic test_back_to_back_sign();
        do_clear();
        drive(8'h38, 8'h38);
        tick();
        drive(8'hB8, 8'h40);
        tick();
        n_checks++; if (acc_tail !== 24'h000100) begin n_fail++; $display("FAIL b2b_first: got %h want %h", acc_tail, 24'h000100); end
        idle();
        tick();
        n_checks++; if (acc_tail !== 24'hFFFF00) begin n_fail++; $display("FAIL b2b_neg: got %h want %h", acc_tail, 24'hFFFF00); end
        n_checks++; if (ovf2 !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b want %b", ovf2, 1'b0); end
    endtask

    task automatic test_formats();
        do_clear();
        fmt_sel = 1'b1;
        drive(8'h3C, 8'h3C);
        tick();
        fmt_sel = 1'b0;
        drive(8'h04, 8'h38);
        tick();
        n_checks++; if (acc_tail !== 24'h000100) begin n_fail++; $display("FAIL e5m2_one: got %h want %h", acc_tail, 24'h000100); end
        drive(8'h08, 8'h38);
        tick();
        n_checks++; if (acc_tail !== 24'h000102) begin n_fail++; $display("FAIL e4m3_denorm: got %h want %h", acc_tail, 24'h000102); end
        idle();
        tick();
        n_checks++; if (acc_tail !== 24'h000106) begin n_fail++; $display("FAIL e4m3_minnorm: got %h want %h", acc_tail, 24'h000106); end
    endtask

    task automatic test_saturation();
        do_clear();
        drive(8'h7E, 8'h7E);
        tick();
        idle();
        tick();
        n_checks++; if (acc_tail !== 24'h7FFFFF) begin n_fail++; $display("FAIL sat_pos: got %h want %h", acc_tail, 24'h7FFFFF); end
        n_checks++; if (ovf2 !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b want %b", ovf2, 1'b1); end
        drive(8'hB8, 8'h38);
        tick();
        tick();
        n_checks++; if (acc_tail !== 24'h7FFEFF) begin n_fail++; $display("FAIL sat_dec1: got %h want %h", acc_tail, 24'h7FFEFF); end
        idle();
        tick();
        n_checks++; if (acc_tail !== 24'h7FFDFF) begin n_fail++; $display("FAIL sat_dec2: got %h want %h", acc_tail, 24'h7FFDFF); end
        drive(8'hFE, 8'h7E);
        tick();
        tick();
        n_checks++; if (acc_tail !== 24'hFFFE00) begin n_fail++; $display("FAIL sat_bigneg: got %h want %h", acc_tail, 24'hFFFE00); end
        idle();
        tick();
        n_checks++; if (acc_tail !== 24'h800000) begin n_fail++; $display("FAIL sat_min: got %h want %h", acc_tail, 24'h800000); end
        n_checks++; if (ovf2 !== 1'b1) begin n_fail++; $display("FAIL sat_ovf_sticky: got %b want %b", ovf2, 1'b1); end
        do_clear();
        n_checks++; if (acc_tail !== 24'h000000) begin n_fail++; $display("FAIL clear_acc: got %h want %h", acc_tail, 24'h000000); end
        n_checks++; if (ovf2 !== 1'b0) begin n_fail++; $display("FAIL clear_ovf: got %b want %b", ovf2, 1'b0); end
    endtask

    task automatic test_nan();
        do_clear();
        drive(8'h7F, 8'h38);
        tick();
        n_checks++; if (nan2 !== 1'b1) begin n_fail++; $display("FAIL nan_e4m3: got %b want %b", nan2, 1'b1); end
        idle();
        tick();
        n_checks++; if (acc_tail !== 24'h000000) begin n_fail++; $display("FAIL nan_no_acc: got %h want %h", acc_tail, 24'h000000); end
        do_clear();
        n_checks++; if (nan2 !== 1'b0) begin n_fail++; $display("FAIL nan_clear: got %b want %b", nan2, 1'b0); end
        in_valid = 1'b0;
        a_in     = 8'h7F;
        b_in     = 8'h38;
        tick();
        tick();
        n_checks++; if (nan2 !== 1'b0) begin n_fail++; $display("FAIL nan_invalid: got %b want %b", nan2, 1'b0); end
        fmt_sel = 1'b1;
        drive(8'h7C, 8'h3C);
        tick();
        idle();
        fmt_sel = 1'b0;
        tick();
        n_checks++; if (nan2 !== 1'b1) begin n_fail++; $display("FAIL inf_e5m2: got %b want %b", nan2, 1'b1); end
        n_checks++; if (acc_tail !== 24'h000000) begin n_fail++; $display("FAIL inf_no_acc: got %h want %h", acc_tail, 24'h000000); end
    endtask

    task automatic test_drain();
        idle();
        drain_en = 1'b1;
        head_in  = 24'h000003;
        tick();
        head_in  = 24'h000002;
        tick();
        head_in  = 24'h000001;
        tick();
        n_checks++; if (acc0 !== 24'h000001) begin n_fail++; $display("FAIL preload_pe0: got %h want %h", acc0, 24'h000001); end
        n_checks++; if (acc1 !== 24'h000002) begin n_fail++; $display("FAIL preload_pe1: got %h want %h", acc1, 24'h000002); end
        head_in = 24'h000000;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (acc_tail !== 24'(3 - i)) begin n_fail++; $display("FAIL drain_tail_%0d: got %h want %h", i, acc_tail, 24'(3 - i)); end
            tick();
        end
        drain_en = 1'b0;
        n_checks++; if (acc_tail !== 24'h000000) begin n_fail++; $display("FAIL drain_empty: got %h want %h", acc_tail, 24'h000000); end
        n_checks++; if (nan2 !== 1'b1) begin n_fail++; $display("FAIL drain_flag_held: got %b want %b", nan2, 1'b1); end
    endtask

    task automatic test_priority();
        do_clear();
        drive(8'h38, 8'h38);
        tick();
        idle();
        drain_en = 1'b1;
        head_in  = 24'h000005;
        tick();
        drain_en = 1'b0;
        n_checks++; if (acc0 !== 24'h000005) begin n_fail++; $display("FAIL drain_load: got %h want %h", acc0, 24'h000005); end
        n_checks++; if (acc_tail !== 24'h000000) begin n_fail++; $display("FAIL drain_discard: got %h want %h", acc_tail, 24'h000000); end
        tick();
        n_checks++; if (acc_tail !== 24'h000000) begin n_fail++; $display("FAIL drain_no_stale: got %h want %h", acc_tail, 24'h000000); end
        drive(8'h38, 8'h38);
        tick();
        idle();
        tick();
        n_checks++; if (acc0 !== 24'h000105) begin n_fail++; $display("FAIL acc_after_drain: got %h want %h", acc0, 24'h000105); end
        clear    = 1'b1;
        drain_en = 1'b1;
        head_in  = 24'h000007;
        drive(8'h38, 8'h38);
        tick();
        clear    = 1'b0;
        drain_en = 1'b0;
        idle();
        n_checks++; if (acc0 !== 24'h000000) begin n_fail++; $display("FAIL clear_beats_drain: got %h want %h", acc0, 24'h000000); end
        tick();
        n_checks++; if (acc_tail !== 24'h000100) begin n_fail++; $display("FAIL clear_keeps_stage1: got %h want %h", acc_tail, 24'h000100); end
    endtask

    task automatic test_async_reset();
        drive(8'h38, 8'h38);
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (acc_tail !== 24'h000000) begin n_fail++; $display("FAIL arst_acc: got %h want %h", acc_tail, 24'h000000); end
        n_checks++; if (a2 !== 8'h00) begin n_fail++; $display("FAIL arst_a_out: got %h want %h", a2, 8'h00); end
        n_checks++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want %b", v2, 1'b0); end
        idle();
        #2;
        rst = 1'b0;
        tick();
        tick();
        n_checks++; if (acc_tail !== 24'h000000) begin n_fail++; $display("FAIL arst_no_stale: got %h want %h", acc_tail, 24'h000000); end
    endtask

    initial begin
        test_reset();
        test_unit();
        test_back_to_back_sign();
        test_formats();
        test_saturation();
        test_nan();
        test_drain();
        test_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
